// File: rtl/attack_sequencer_if.sv
// rtl/attack_sequencer_if.sv - fighter attack sequencer control/status bundle
interface attack_sequencer_if;
    logic       frame_tick;
    logic       enable;
    logic       btn_light;
    logic       btn_medium;
    logic       btn_heavy;
    logic [1:0] attack_state;
    logic [1:0] pose;
    logic       busy;
    logic [7:0] strike_count;

    modport master (
        output frame_tick, enable, btn_light, btn_medium, btn_heavy,
        input  attack_state, pose, busy, strike_count
    );

    modport slave (
        input  frame_tick, enable, btn_light, btn_medium, btn_heavy,
        output attack_state, pose, busy, strike_count
    );
endinterface

// File: rtl/attack_sequencer.sv
// rtl/attack_sequencer.sv - per-fighter windup/strike/recover attack FSM
module attack_sequencer #(
    parameter int WINDUP_L  = 2,
    parameter int WINDUP_M  = 4,
    parameter int WINDUP_H  = 8,
    parameter int RECOVER_L = 4,
    parameter int RECOVER_M = 8,
    parameter int RECOVER_H = 16
) (
    input  logic               clk,
    input  logic               reset,
    attack_sequencer_if.slave  bus
);
    // Encoding doubles as the sprite pose code.
    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_WINDUP  = 2'b01,
        S_STRIKE  = 2'b10,
        S_RECOVER = 2'b11
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [5:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_type, w_type_nxt;
    logic       r_buf_valid, w_buf_valid_nxt;
    logic [1:0] r_buf_type, w_buf_type_nxt;
    logic [1:0] r_attack, w_attack_nxt;
    logic [7:0] r_count, w_count_nxt;
    logic       r_prev_l, r_prev_m, r_prev_h;
    logic [1:0] w_press;

    function automatic logic [5:0] f_windup(input logic [1:0] t);
        case (t)
            2'b11:   return 6'(WINDUP_H);
            2'b10:   return 6'(WINDUP_M);
            default: return 6'(WINDUP_L);
        endcase
    endfunction

    function automatic logic [5:0] f_recover(input logic [1:0] t);
        case (t)
            2'b11:   return 6'(RECOVER_H);
            2'b10:   return 6'(RECOVER_M);
            default: return 6'(RECOVER_L);
        endcase
    endfunction

    // Rising-edge detect with heavy > medium > light priority; 00 means no press.
    always_comb begin
        w_press = 2'b00;
        if (bus.btn_heavy && !r_prev_h)
            w_press = 2'b11;
        else if (bus.btn_medium && !r_prev_m)
            w_press = 2'b10;
        else if (bus.btn_light && !r_prev_l)
            w_press = 2'b01;
    end

    // Next-state, countdown, pending buffer and strike outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_type_nxt      = r_type;
        w_buf_valid_nxt = r_buf_valid;
        w_buf_type_nxt  = r_buf_type;
        w_attack_nxt    = 2'b00;
        w_count_nxt     = r_count;

        if (!bus.enable) begin
            w_state_nxt     = S_IDLE;
            w_buf_valid_nxt = 1'b0;
        end else begin
            // Presses while an attack is in flight queue up; the newest one wins.
            if (r_state != S_IDLE && w_press != 2'b00) begin
                w_buf_valid_nxt = 1'b1;
                w_buf_type_nxt  = w_press;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_press != 2'b00) begin
                        w_type_nxt      = w_press;
                        w_cnt_nxt       = f_windup(w_press);
                        w_state_nxt     = S_WINDUP;
                        w_buf_valid_nxt = 1'b0;
                    end else if (r_buf_valid) begin
                        w_type_nxt      = r_buf_type;
                        w_cnt_nxt       = f_windup(r_buf_type);
                        w_state_nxt     = S_WINDUP;
                        w_buf_valid_nxt = 1'b0;
                    end
                end
                S_WINDUP: begin
                    if (r_cnt == 6'd0) begin
                        // Strike code and count are registered together with the STRIKE state.
                        w_state_nxt  = S_STRIKE;
                        w_attack_nxt = r_type;
                        w_count_nxt  = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
                    end else if (bus.frame_tick) begin
                        w_cnt_nxt = r_cnt - 6'd1;
                    end
                end
                S_STRIKE: begin
                    w_cnt_nxt   = f_recover(r_type);
                    w_state_nxt = S_RECOVER;
                end
                S_RECOVER: begin
                    if (r_cnt == 6'd0)
                        w_state_nxt = S_IDLE;
                    else if (bus.frame_tick)
                        w_cnt_nxt = r_cnt - 6'd1;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State and datapath registers; button history tracks levels even in reset.
    always_ff @(posedge clk) begin
        r_prev_l <= bus.btn_light;
        r_prev_m <= bus.btn_medium;
        r_prev_h <= bus.btn_heavy;
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 6'd0;
            r_type      <= 2'b00;
            r_buf_valid <= 1'b0;
            r_buf_type  <= 2'b00;
            r_attack    <= 2'b00;
            r_count     <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_type      <= w_type_nxt;
            r_buf_valid <= w_buf_valid_nxt;
            r_buf_type  <= w_buf_type_nxt;
            r_attack    <= w_attack_nxt;
            r_count     <= w_count_nxt;
        end
    end

    assign bus.attack_state = r_attack;
    assign bus.pose         = r_state;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.strike_count = r_count;
endmodule
